// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the systolic array operand feeder.
//   - DEF_N / DEF_IN_WORD_SIZE / DEF_K_MAX : default array dimension,
//     operand width and maximum beats per tile
//   - feeder_state_t : tile sequencer states
//   - drain_len()    : cycles needed for the last operand pair to cross the
//     array diagonal (2N-1)
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEF_N            = 4;
    localparam int DEF_IN_WORD_SIZE = 8;
    localparam int DEF_K_MAX        = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } feeder_state_t;

    // The last beat enters lane 0 and must ripple to PE(N-1,N-1).
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
//   Fixed-depth delay line: D back-to-back registers of W bits. One instance
//   per feeder lane produces the diagonal skew in front of the array.
//   Ports:
//     clk     - clock
//     rst_n   - asynchronous active-low reset, clears every stage
//     data    - word entering the line
//     delayed - word that entered D cycles earlier
// -----------------------------------------------------------------------------
module skew_line #(
    parameter int D = 1,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data,
    output logic [W-1:0] delayed
);

    logic [W-1:0] stage [D];

    // NOTE: this is a register chain, not a RAM: every stage must reset so a
    // mid-tile reset cannot leak stale operands into the next tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < D; j++) stage[j] <= '0;
        end else begin
            stage[0] <= data;
            for (int j = 1; j < D; j++) stage[j] <= stage[j-1];
        end
    end

    assign delayed = stage[D-1];

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Operand feeder for an N x N MAC systolic array. Accepts one A-column /
//   B-row beat per cycle, skews lane i by i extra cycles, and sequences one
//   tile: clear array, feed up to K_MAX beats, drain 2N-1 cycles, done pulse.
//   Optional feature macro: SYSTOLIC_FEEDER_BUBBLE_CNT_EN adds bubble_cnt.
//   Ports:
//     clk, clear_n      - clock, asynchronous active-low reset
//     start             - begin a tile (IDLE only)
//     in_valid/in_ready - beat handshake (ready only in FEED)
//     in_last           - final beat of the tile
//     a_in, b_in        - A column / B row, lane 0 in MSBs
//     a_edge, b_edge    - skewed operands to array west / north edges
//     array_clear       - one-cycle registered clear to the array
//     busy              - sequencer not idle
//     tile_done         - one-cycle pulse, array results final
//     k_overflow        - sticky, tile truncated at K_MAX
//     bubble_cnt        - (macro only) FEED cycles with no accepted beat
// -----------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int IN_WORD_SIZE = DEF_IN_WORD_SIZE,
    parameter int K_MAX        = DEF_K_MAX
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [N*IN_WORD_SIZE-1:0] a_in,
    input  logic [N*IN_WORD_SIZE-1:0] b_in,
    output logic [N*IN_WORD_SIZE-1:0] a_edge,
    output logic [N*IN_WORD_SIZE-1:0] b_edge,
    output logic                      array_clear,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      k_overflow
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]               bubble_cnt
`endif
);

    localparam int DRAIN_LEN = drain_len(N);
    localparam int VW        = N * IN_WORD_SIZE;
    localparam int BEAT_W    = $clog2(K_MAX + 1);
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    feeder_state_t      state, state_next;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               at_k_max;
    logic               beat_final;
    logic               drain_end;
    logic [VW-1:0]      inject_a, inject_b;

    assign in_ready   = (state == S_FEED);
    assign busy       = (state != S_IDLE);
    assign accept     = in_valid && in_ready;
    assign at_k_max   = (beat_cnt == BEAT_W'(K_MAX - 1));
    // A K_MAX-th beat ends the tile even without in_last.
    assign beat_final = accept && (in_last || at_k_max);
    assign drain_end  = (state == S_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_LEN - 1));

    // Idle slots inject zero pairs; a zero product leaves array sums intact.
    assign inject_a = accept ? a_in : '0;
    assign inject_b = accept ? b_in : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)      state_next = S_CLEAR;
            S_CLEAR:                 state_next = S_FEED;
            S_FEED:  if (beat_final) state_next = S_DRAIN;
            S_DRAIN: if (drain_end)  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            array_clear <= 1'b0;
            tile_done   <= 1'b0;
            k_overflow  <= 1'b0;
        end else begin
            // Registered decode of the upcoming state: high exactly in CLEAR.
            array_clear <= (state_next == S_CLEAR);
            tile_done   <= drain_end;

            if (state == S_IDLE && start) begin
                beat_cnt   <= '0;
                k_overflow <= 1'b0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
                if (at_k_max && !in_last) k_overflow <= 1'b1;
            end

            if (state == S_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
            else                  drain_cnt <= '0;
        end
    end

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            bubble_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            bubble_cnt <= '0;
        end else if (state == S_FEED && !in_valid && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

    // Lane i passes through 1+i registers on each edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.D(1 + i), .W(IN_WORD_SIZE)) u_skew_a (
            .clk     (clk),
            .rst_n   (clear_n),
            .data    (inject_a[(N-1-i)*IN_WORD_SIZE +: IN_WORD_SIZE]),
            .delayed (a_edge[(N-1-i)*IN_WORD_SIZE +: IN_WORD_SIZE])
        );
        skew_line #(.D(1 + i), .W(IN_WORD_SIZE)) u_skew_b (
            .clk     (clk),
            .rst_n   (clear_n),
            .data    (inject_b[(N-1-i)*IN_WORD_SIZE +: IN_WORD_SIZE]),
            .delayed (b_edge[(N-1-i)*IN_WORD_SIZE +: IN_WORD_SIZE])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//   Self-checking bench for systolic_feeder (N=4, 8-bit words, K_MAX=4).
//   Accepted beats go into a scoreboard queue; every cycle the skewed edges
//   are compared lane by lane against it. A behavioural 4x4 MAC array sits on
//   the edges to confirm skew alignment end-to-end.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int KM   = 4;
    localparam int VW   = N * W;
    localparam int DLEN = 2 * N - 1;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [VW-1:0] a_in = '0;
    logic [VW-1:0] b_in = '0;
    logic          in_ready, array_clear, busy, tile_done, k_overflow;
    logic [VW-1:0] a_edge, b_edge;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic drv_acc = 1'b0;

    typedef struct {
        int            edge_no;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic          start, valid, last, acc;
        logic [VW-1:0] a, b;
        logic          ready, busy, clr, done, ovf;
    } step_t;
    step_t tbl[$];

    systolic_feeder #(.N(N), .IN_WORD_SIZE(W), .K_MAX(KM)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .a_in        (a_in),
        .b_in        (b_in),
        .a_edge      (a_edge),
        .b_edge      (b_edge),
        .array_clear (array_clear),
        .busy        (busy),
        .tile_done   (tile_done),
        .k_overflow  (k_overflow)
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
        return v[(N-1-i)*W +: W];
    endfunction

    // Lane i in the period after edge cyc shows the beat accepted at edge cyc-i.
    function automatic logic [VW-1:0] exp_edge(input bit is_b);
        logic [VW-1:0] r = '0;
        for (int i = 0; i < N; i++)
            foreach (sb[k])
                if (sb[k].edge_no == cyc - i)
                    r[(N-1-i)*W +: W] = is_b ? lane(sb[k].b, i) : lane(sb[k].a, i);
        return r;
    endfunction

    always @(posedge clk) begin
        if (drv_acc) sb.push_back('{cyc + 1, a_in, b_in});
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        check("a_edge", a_edge, exp_edge(1'b0));
        check("b_edge", b_edge, exp_edge(1'b1));
        while (sb.size() > 0 && sb[0].edge_no <= cyc - (N - 1)) void'(sb.pop_front());
    end

    // Behavioural output-stationary MAC array on the feeder edges.
    logic [W-1:0]  ain [N][N];
    logic [W-1:0]  bin [N][N];
    logic [W-1:0]  pa  [N][N];
    logic [W-1:0]  pb  [N][N];
    logic [31:0]   psum[N][N];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            ain[r][0] = lane(a_edge, r);
            for (int c = 1; c < N; c++) ain[r][c] = pa[r][c-1];
        end
        for (int c = 0; c < N; c++) begin
            bin[0][c] = lane(b_edge, c);
            for (int r = 1; r < N; r++) bin[r][c] = pb[r-1][c];
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                pa[r][c]   <= ain[r][c];
                pb[r][c]   <= bin[r][c];
                psum[r][c] <= array_clear ? 32'd0 : psum[r][c] + ain[r][c] * bin[r][c];
            end
    end

    task automatic drive(input logic s, input logic v, input logic l,
                         input logic [VW-1:0] a, input logic [VW-1:0] b, input logic ex_acc);
        @(posedge clk);
        #1;
        start = s; in_valid = v; in_last = l; a_in = a; b_in = b; drv_acc = ex_acc;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Period index n counts periods after the final accept edge; done at 2N-1.
    task automatic wait_done(input string name, input int n0, input int extra_valid);
        int n = n0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            drive(1'b0, (n - n0) < extra_valid, 1'b0, $urandom, $urandom, 1'b0);
            if (tile_done) seen = 1'b1;
            else n++;
        end
        check(name, seen ? 64'(n) : 64'hFFFF, 64'(DLEN));
        if (seen) check({name, "_busy"}, busy, 0);
    endtask

    task automatic add(input logic s, input logic v, input logic l, input logic x,
                       input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic rdy, input logic bsy, input logic clr,
                       input logic dn, input logic ovf);
        tbl.push_back('{s, v, l, x, a, b, rdy, bsy, clr, dn, ovf});
    endtask

    task automatic run_skew(input string name);
        logic [VW-1:0] ea, eb;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        drive(1'b0, 1'b1, 1'b1, 32'h01020304, 32'h05060708, 1'b1);
        for (int n = 0; n <= N; n++) begin
            idle();
            ea = '0;
            eb = '0;
            if (n < N) begin
                ea[(N-1-n)*W +: W] = W'(n + 1);
                eb[(N-1-n)*W +: W] = W'(n + 5);
            end
            check($sformatf("%s_a%0d", name, n), a_edge, ea);
            check($sformatf("%s_b%0d", name, n), b_edge, eb);
        end
        wait_done({name, "_done"}, N + 1, 0);
    endtask

    initial begin
        logic [VW-1:0] ra[3];
        logic [VW-1:0] rb[3];
        logic [31:0]   cref;
        int            dn_cnt;

        // Reset state.
        #12;
        check("rst_a_edge", a_edge, 0);
        check("rst_b_edge", b_edge, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_clr", array_clear, 0);
        check("rst_done", tile_done, 0);
        check("rst_ovf", k_overflow, 0);
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        check("rst_bubble", bubble_cnt, 0);
`endif
        @(negedge clk);
        clear_n = 1'b1;

        // Cycle table: K=2 tile with a bubble, start coincident with done,
        // then K=1 tile with start ignored in DRAIN.
        add(1, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 1, 0, 0);
        add(0, 1, 0, 1, 32'h11223344, 32'h55667788, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, '0, '0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 32'h99AABBCC, 32'hDDEEFF01, 1, 1, 0, 0, 0);
        for (int i = 0; i < DLEN; i++)
            add(0, i == 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, '0, '0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, '0, '0, 0, 1, 1, 0, 0);
        add(0, 1, 1, 1, 32'h0A0B0C0D, 32'h01020304, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, '0, '0, 0, 1, 0, 0, 0);
        for (int i = 1; i < DLEN; i++)
            add(0, 0, 0, 0, '0, '0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, '0, '0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].valid, tbl[i].last, tbl[i].a, tbl[i].b, tbl[i].acc);
            check($sformatf("t%0d_ready", i), in_ready, tbl[i].ready);
            check($sformatf("t%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("t%0d_clr", i), array_clear, tbl[i].clr);
            check($sformatf("t%0d_done", i), tile_done, tbl[i].done);
            check($sformatf("t%0d_ovf", i), k_overflow, tbl[i].ovf);
        end

        // Single-beat skew.
        run_skew("skew");

        // Bubbles: K=3, two empty FEED cycles between beats 1 and 2.
        for (int k = 0; k < 3; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        check("bub_cleared", bubble_cnt, 0);
`endif
        drive(1'b0, 1'b1, 1'b0, ra[0], rb[0], 1'b1);
        idle();
        idle();
        drive(1'b0, 1'b1, 1'b0, ra[1], rb[1], 1'b1);
        drive(1'b0, 1'b1, 1'b1, ra[2], rb[2], 1'b1);
        wait_done("bub_done", 0, 0);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                cref = 0;
                for (int k = 0; k < 3; k++) cref += lane(ra[k], r) * lane(rb[k], c);
                check($sformatf("mac_%0d_%0d", r, c), psum[r][c], cref);
            end
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        check("bub_cnt", bubble_cnt, 2);
`endif

        // Overflow: six valid beats without in_last, K_MAX=4.
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        for (int k = 0; k < KM; k++) begin
            drive(1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b1);
            check($sformatf("ovf_ready%0d", k), in_ready, 1);
        end
        drive(1'b0, 1'b1, 1'b0, $urandom, $urandom, 1'b0);
        check("ovf_ready_low", in_ready, 0);
        check("ovf_flag", k_overflow, 1);
        wait_done("ovf_done", 1, 1);
        check("ovf_sticky", k_overflow, 1);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        check("ovf_cleared", k_overflow, 0);
        drive(1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        wait_done("ovf_next_done", 0, 0);
        check("ovf_next_flag", k_overflow, 0);

        // Reset mid-FEED after two beats.
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        drive(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1);
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        in_valid = 1'b0;
        drv_acc = 1'b0;
        sb.delete();
        #1;
        check("mid_a_edge", a_edge, 0);
        check("mid_b_edge", b_edge, 0);
        check("mid_busy", busy, 0);
        check("mid_done", tile_done, 0);
        @(negedge clk);
        clear_n = 1'b1;
        dn_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (tile_done) dn_cnt++;
        end
        check("mid_no_done", dn_cnt, 0);
        run_skew("skew_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
